// File: rtl/vpg_seq_pkg.sv
// Shared definitions for the VPG mode-change sequencer: state encoding,
// default timing constants and counter-width helpers.
package vpg_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_DRAIN     = 3'd1,
        SEQ_KICK      = 3'd2,
        SEQ_GUARD     = 3'd3,
        SEQ_WAIT_LOCK = 3'd4,
        SEQ_RELEASE   = 3'd5
    } seq_state_e;

    localparam logic [3:0] DEF_DEFAULT_MODE        = 4'd0;
    localparam int         DEF_DRAIN_CYCLES        = 16;
    localparam int         DEF_CHANGE_PULSE_CYCLES = 4;
    localparam int         DEF_GUARD_CYCLES        = 64;
    localparam int         DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int         DEF_TIMEOUT_CYCLES      = 1048576;
    localparam int         DEF_MAX_RETRIES         = 2;

    // Width able to hold the terminal count itself (counters stop there).
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronizes the asynchronous PLL lock and qualifies it: lock_stable is
// raised in the cycle the LOCK_STABLE_CYCLES-th consecutive synchronized-high
// sample is seen while enabled. The synchronizer delay counts toward the run.
module pll_lock_filter
    import vpg_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_locked,
    input  logic clear,
    input  logic enable,
    output logic lock_stable
);

    localparam int              SW        = cnt_width(LOCK_STABLE_CYCLES);
    localparam logic [SW-1:0]   LOCK_TERM = SW'(LOCK_STABLE_CYCLES);
    localparam logic [SW-1:0]   LOCK_LAST = SW'(LOCK_STABLE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [SW-1:0] stable_cnt_r;
    logic [SW-1:0] stable_cnt_nxt_s;

    // Two-flop synchronizer for the lock input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            sync2_r <= sync1_r;
        end
    end

    // Consecutive-high counter: cleared on GUARD entry, zeroed on any low, saturating.
    always_comb begin
        stable_cnt_nxt_s = stable_cnt_r;
        if (clear) begin
            stable_cnt_nxt_s = {SW{1'b0}};
        end else if (enable) begin
            if (!sync2_r) begin
                stable_cnt_nxt_s = {SW{1'b0}};
            end else if (stable_cnt_r != LOCK_TERM) begin
                stable_cnt_nxt_s = stable_cnt_r + SW'(1'b1);
            end else begin
                stable_cnt_nxt_s = stable_cnt_r;
            end
        end else begin
            stable_cnt_nxt_s = stable_cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt_r <= {SW{1'b0}};
        end else begin
            stable_cnt_r <= stable_cnt_nxt_s;
        end
    end

    // Depends only on registered state so the sequencer's next-state logic has no loop through clear.
    assign lock_stable = enable && sync2_r &&
                         ((stable_cnt_r == LOCK_LAST) || (stable_cnt_r == LOCK_TERM));

endmodule

// File: rtl/vpg_mode_sequencer.sv
// Video-mode change sequencer: holds the VPG in reset, strobes the PLL
// reconfiguration controller with the new mode, waits for a stable lock with
// timeout/retry, then releases the VPG. A one-entry pending register buffers
// the most recent request; reset preloads it so DEFAULT_MODE configures itself.
module vpg_mode_sequencer
    import vpg_seq_pkg::*;
#(
    parameter logic [3:0] DEFAULT_MODE        = DEF_DEFAULT_MODE,
    parameter int         DRAIN_CYCLES        = DEF_DRAIN_CYCLES,
    parameter int         CHANGE_PULSE_CYCLES = DEF_CHANGE_PULSE_CYCLES,
    parameter int         GUARD_CYCLES        = DEF_GUARD_CYCLES,
    parameter int         LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int         TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES,
    parameter int         MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mode_req,
    input  logic       mode_req_valid,
    input  logic       pll_locked,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       vpg_reset,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       err_flag,
    output logic [3:0] cur_mode
);

    localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
    localparam logic [2:0] ST_DRAIN     = SEQ_DRAIN;
    localparam logic [2:0] ST_KICK      = SEQ_KICK;
    localparam logic [2:0] ST_GUARD     = SEQ_GUARD;
    localparam logic [2:0] ST_WAIT_LOCK = SEQ_WAIT_LOCK;
    localparam logic [2:0] ST_RELEASE   = SEQ_RELEASE;

    localparam int PW = cnt_width(max3(DRAIN_CYCLES, CHANGE_PULSE_CYCLES, GUARD_CYCLES));
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int RW = cnt_width(MAX_RETRIES);

    localparam logic [PW-1:0] DRAIN_LAST  = PW'(DRAIN_CYCLES - 1);
    localparam logic [PW-1:0] CHANGE_LAST = PW'(CHANGE_PULSE_CYCLES - 1);
    localparam logic [PW-1:0] GUARD_LAST  = PW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    logic [2:0]    state_r,       state_nxt_s;
    logic [PW-1:0] phase_cnt_r,   phase_cnt_nxt_s;
    logic [TW-1:0] tmo_cnt_r,     tmo_cnt_nxt_s;
    logic [RW-1:0] retry_r,       retry_nxt_s;
    logic [3:0]    mode_r,        mode_nxt_s;
    logic [3:0]    cur_mode_r,    cur_mode_nxt_s;
    logic          cfg_valid_r,   cfg_valid_nxt_s;
    logic          vpg_reset_r,   vpg_reset_nxt_s;
    logic          err_flag_r,    err_flag_nxt_s;
    logic          done_r,        done_nxt_s;
    logic          error_r,       error_nxt_s;
    logic          mode_change_r;
    logic          busy_r;
    logic          pend_valid_r;
    logic [3:0]    pend_mode_r;
    logic          consume_s;
    logic          guard_entry_s;
    logic          lock_stable_s;
    logic          timeout_s;

    assign guard_entry_s = (state_r == ST_KICK) && (phase_cnt_r == CHANGE_LAST);
    assign timeout_s     = (tmo_cnt_r == TMO_LAST);

    pll_lock_filter #(
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES)
    ) u_lock_filter (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .clear       (guard_entry_s),
        .enable      (state_r == ST_WAIT_LOCK),
        .lock_stable (lock_stable_s)
    );

    // Next-state and next-output logic of the sequencing FSM.
    always_comb begin
        state_nxt_s     = state_r;
        phase_cnt_nxt_s = phase_cnt_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        retry_nxt_s     = retry_r;
        mode_nxt_s      = mode_r;
        cur_mode_nxt_s  = cur_mode_r;
        cfg_valid_nxt_s = cfg_valid_r;
        vpg_reset_nxt_s = vpg_reset_r;
        err_flag_nxt_s  = err_flag_r;
        done_nxt_s      = 1'b0;
        error_nxt_s     = 1'b0;
        consume_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_valid_r) begin
                    consume_s = 1'b1;
                    // Already running this mode cleanly: acknowledge without touching the PLL.
                    if ((pend_mode_r == cur_mode_r) && !err_flag_r && cfg_valid_r) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        mode_nxt_s      = pend_mode_r;
                        err_flag_nxt_s  = 1'b0;
                        retry_nxt_s     = {RW{1'b0}};
                        phase_cnt_nxt_s = {PW{1'b0}};
                        vpg_reset_nxt_s = 1'b1;
                        state_nxt_s     = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (phase_cnt_r == DRAIN_LAST) begin
                    phase_cnt_nxt_s = {PW{1'b0}};
                    state_nxt_s     = ST_KICK;
                end else begin
                    phase_cnt_nxt_s = phase_cnt_r + PW'(1'b1);
                end
            end
            ST_KICK: begin
                if (guard_entry_s) begin
                    phase_cnt_nxt_s = {PW{1'b0}};
                    tmo_cnt_nxt_s   = {TW{1'b0}};
                    state_nxt_s     = ST_GUARD;
                end else begin
                    phase_cnt_nxt_s = phase_cnt_r + PW'(1'b1);
                end
            end
            ST_GUARD, ST_WAIT_LOCK: begin
                if ((state_r == ST_WAIT_LOCK) && lock_stable_s) begin
                    state_nxt_s = ST_RELEASE;
                end else if (timeout_s) begin
                    if (retry_r < RETRY_MAX) begin
                        retry_nxt_s     = retry_r + RW'(1'b1);
                        phase_cnt_nxt_s = {PW{1'b0}};
                        state_nxt_s     = ST_DRAIN;
                    end else begin
                        error_nxt_s    = 1'b1;
                        err_flag_nxt_s = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TW'(1'b1);
                    if ((state_r == ST_GUARD) && (phase_cnt_r == GUARD_LAST)) begin
                        phase_cnt_nxt_s = {PW{1'b0}};
                        state_nxt_s     = ST_WAIT_LOCK;
                    end else if (state_r == ST_GUARD) begin
                        phase_cnt_nxt_s = phase_cnt_r + PW'(1'b1);
                    end else begin
                        phase_cnt_nxt_s = phase_cnt_r;
                    end
                end
            end
            ST_RELEASE: begin
                vpg_reset_nxt_s = 1'b0;
                cur_mode_nxt_s  = mode_r;
                cfg_valid_nxt_s = 1'b1;
                done_nxt_s      = 1'b1;
                state_nxt_s     = ST_IDLE;
            end
            default: begin
                vpg_reset_nxt_s = 1'b1;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            phase_cnt_r   <= {PW{1'b0}};
            tmo_cnt_r     <= {TW{1'b0}};
            retry_r       <= {RW{1'b0}};
            mode_r        <= DEFAULT_MODE;
            cur_mode_r    <= DEFAULT_MODE;
            cfg_valid_r   <= 1'b0;
            vpg_reset_r   <= 1'b1;
            err_flag_r    <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            mode_change_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            phase_cnt_r   <= phase_cnt_nxt_s;
            tmo_cnt_r     <= tmo_cnt_nxt_s;
            retry_r       <= retry_nxt_s;
            mode_r        <= mode_nxt_s;
            cur_mode_r    <= cur_mode_nxt_s;
            cfg_valid_r   <= cfg_valid_nxt_s;
            vpg_reset_r   <= vpg_reset_nxt_s;
            err_flag_r    <= err_flag_nxt_s;
            done_r        <= done_nxt_s;
            error_r       <= error_nxt_s;
            mode_change_r <= (state_nxt_s == ST_KICK);
            busy_r        <= (state_nxt_s != ST_IDLE);
        end
    end

    // One-entry, last-writer-wins request buffer; a new request beats consumption.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_r <= 1'b1;
            pend_mode_r  <= DEFAULT_MODE;
        end else if (mode_req_valid) begin
            pend_valid_r <= 1'b1;
            pend_mode_r  <= mode_req;
        end else if (consume_s) begin
            pend_valid_r <= 1'b0;
            pend_mode_r  <= pend_mode_r;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_mode_r  <= pend_mode_r;
        end
    end

    assign mode        = mode_r;
    assign mode_change = mode_change_r;
    assign vpg_reset   = vpg_reset_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign err_flag    = err_flag_r;
    assign cur_mode    = cur_mode_r;

endmodule
